ex_mem_stage: RTL and testbench
===============================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameters SHALL be one per line, as name, default, meaning:
- DATA_W, 8, datapath and memory data width.
- INSTR_W, 19, instruction word width.
- TIMEOUT_CYCLES, 15, watchdog limit in cycles.
REQ-002 Ports SHALL be one per line, as name, direction, width, meaning:
- clk, in, 1, single clock, rising edge.
- reset, in, 1, asynchronous, active-high.
- ex_valid, in, 1, EX presents an instruction.
- ex_alu_out, in, DATA_W, ALU result; also the memory address.
- ex_shift_out, in, DATA_W, shifter result.
- ex_store_data, in, DATA_W, store data.
- ex_instruction, in, INSTR_W, instruction word.
- ex_reg_write_mux, in, 2, write-back source select.
- ex_mem_read, in, 1, load.
- ex_mem_write, in, 1, store.
- flush, in, 1, squash the instruction being accepted.
- stall, out, 1, hold EX/upstream.
- mem_req, out, 1, data-memory request.
- mem_we, out, 1, write enable.
- mem_addr, out, DATA_W, address.
- mem_wdata, out, DATA_W, write data.
- mem_rdata, in, DATA_W, read data.
- mem_ack, in, 1, access complete.
- EX_MEM_mem_out_data, out, DATA_W, load result.
- EX_MEM_alu_out, out, DATA_W, registered ALU result.
- EX_MEM_shift_out, out, DATA_W, registered shifter result.
- EX_MEM_instruction, out, INSTR_W, registered instruction.
- EX_MEM_reg_write_mux, out, 2, registered select.
- EX_MEM_valid, out, 1, outputs carry a live instruction.
- mem_err, out, 1, sticky timeout flag.

Function
REQ-003 FSM states SHALL be IDLE and ACCESS; stall SHALL be a registered output, equal to (state==ACCESS).
REQ-004 In IDLE, at each edge: if ex_valid and not flush and neither mem flag is set, all EX_MEM_* SHALL load the ex_* values, EX_MEM_mem_out_data SHALL be 0, EX_MEM_valid SHALL be 1 (latency 1 cycle).
REQ-005 In IDLE with flush=1 or ex_valid=0, EX_MEM_valid SHALL be 0 at the next edge; other EX_MEM_* SHALL hold; no access is started.
REQ-006 In IDLE with ex_valid=1, flush=0, and ex_mem_read or ex_mem_write: the instruction SHALL be captured, state SHALL go to ACCESS, EX_MEM_valid SHALL be 0.
REQ-007 If ex_mem_read and ex_mem_write are both set, the access SHALL be a write.
REQ-008 In ACCESS: mem_req=1; mem_we=captured write flag; mem_addr=captured alu_out; mem_wdata=captured store_data. All SHALL be stable until ack.
REQ-009 mem_ack SHALL be sampled only in ACCESS. At the ack edge:
- EX_MEM_* SHALL load the captured fields.
- EX_MEM_mem_out_data SHALL be mem_rdata for a load, 0 for a store.
- EX_MEM_valid SHALL be 1.
- State SHALL return to IDLE.
- stall SHALL fall at that edge.
REQ-010 flush during ACCESS SHALL be ignored; the access SHALL always complete.
REQ-011 ex_* inputs SHALL be ignored while stall=1.
REQ-012 Back-to-back memory instructions SHALL incur one IDLE cycle between accesses (mem_req low for at least 1 cycle).

Reset
REQ-013 reset SHALL asynchronously force:
- state=IDLE;
- stall, mem_req, mem_we, EX_MEM_valid, mem_err = 0;
- mem_addr, mem_wdata, all EX_MEM_* data/instruction/select = 0.
REQ-014 Reset mid-ACCESS SHALL drop mem_req immediately and discard the captured instruction.

Configuration
REQ-015 With macro EX_MEM_STAGE_TIMEOUT_EN defined, a cycle counter SHALL run in ACCESS. After TIMEOUT_CYCLES cycles without ack:
- the access SHALL be aborted;
- state SHALL return to IDLE;
- EX_MEM_valid SHALL be 0;
- mem_err SHALL set and hold until reset.
The counter SHALL clear on entry to ACCESS.
REQ-016 Without EX_MEM_STAGE_TIMEOUT_EN, ACCESS SHALL wait indefinitely for ack and mem_err SHALL be tied 0; the port SHALL remain.

Structure
REQ-017 Shared package ex_mem_pkg SHALL hold:
- the state enum (IDLE, ACCESS);
- DATA_W and INSTR_W defaults;
- the reg_write_mux encodings.
REQ-018 The watchdog SHALL be one sub-module, mem_timeout_ctr, instantiated only under the macro.

Verification
REQ-019 ALU op, alu_out=8'h3C, ex_valid=1 -> next edge EX_MEM_alu_out=8'h3C, valid=1, mem_out_data=0, stall=0.
REQ-020 Load at addr 8'h10, ack 3 cycles after mem_req rises with rdata=8'hA5 -> stall high 3 cycles, then EX_MEM_mem_out_data=8'hA5, valid=1 for one cycle.
REQ-021 Store addr 8'h20 data 8'h77 with flush pulsed mid-ACCESS -> mem_we=1, mem_wdata=8'h77 held until ack, completes with valid=1.
REQ-022 reset asserted 1 cycle after mem_req rises -> mem_req=0 and stall=0 immediately, all outputs 0.
REQ-023 With macro and TIMEOUT_CYCLES=15, no ack -> abort after 15 ACCESS cycles, mem_err=1 sticky, valid=0; without macro, stall stays 1 and mem_err=0.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// Shared types and defaults for the EX->MEM pipeline stage.
// Holds the access FSM state encoding, width defaults and write-back select codes.
// No logic; imported by ex_mem_stage and mem_timeout_ctr.
package ex_mem_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int INSTR_W_DEF = 19;

  // Access FSM: IDLE accepts from EX, ACCESS holds a memory request open.
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // reg_write_mux encodings: which result the write-back stage selects.
  localparam logic [1:0] WB_SEL_ALU   = 2'd0;
  localparam logic [1:0] WB_SEL_SHIFT = 2'd1;
  localparam logic [1:0] WB_SEL_MEM   = 2'd2;
  localparam logic [1:0] WB_SEL_PC    = 2'd3;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Watchdog for an outstanding data-memory access; flags when the limit is reached.
// Latency: expired is combinational from the count, asserted in the final allowed cycle.
// Backpressure: none; start clears the count, active advances it each cycle.
module mem_timeout_ctr
  import ex_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic active,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;

  // Count cycles spent in ACCESS; a fresh access always starts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (active) begin
      cnt <= cnt + 1'b1;
    end
  end

  // The edge that ends the TIMEOUT_CYCLES-th ACCESS cycle sees cnt == limit-1.
  assign expired = active && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a blocking data-memory access FSM (IDLE/ACCESS).
// Latency: 1 cycle for non-memory ops; memory ops complete on the edge mem_ack is seen.
// Backpressure: stall is high for the whole access; optional watchdog via EX_MEM_STAGE_TIMEOUT_EN.
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int INSTR_W        = INSTR_W_DEF,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ex_valid,
  input  logic [DATA_W-1:0]  ex_alu_out,
  input  logic [DATA_W-1:0]  ex_shift_out,
  input  logic [DATA_W-1:0]  ex_store_data,
  input  logic [INSTR_W-1:0] ex_instruction,
  input  logic [1:0]         ex_reg_write_mux,
  input  logic               ex_mem_read,
  input  logic               ex_mem_write,
  input  logic               flush,
  output logic               stall,
  output logic               mem_req,
  output logic               mem_we,
  output logic [DATA_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_ack,
  output logic [DATA_W-1:0]  EX_MEM_mem_out_data,
  output logic [DATA_W-1:0]  EX_MEM_alu_out,
  output logic [DATA_W-1:0]  EX_MEM_shift_out,
  output logic [INSTR_W-1:0] EX_MEM_instruction,
  output logic [1:0]         EX_MEM_reg_write_mux,
  output logic               EX_MEM_valid,
  output logic               mem_err
);

  state_t state, state_nxt;

  logic take_alu;     // non-memory instruction passes straight through
  logic take_mem;     // memory instruction captured, access begins
  logic ack_done;     // access completed by mem_ack
  logic abort;        // access abandoned by the watchdog
  logic timeout_hit;

  // Fields held while the access is outstanding; mem_addr/mem_wdata/mem_we
  // double as the captured alu_out, store data and write flag.
  logic [DATA_W-1:0]  cap_shift;
  logic [INSTR_W-1:0] cap_instr;
  logic [1:0]         cap_mux;

  // Next-state and per-cycle actions; EX inputs only matter in IDLE.
  always_comb begin
    state_nxt = state;
    take_alu  = 1'b0;
    take_mem  = 1'b0;
    ack_done  = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (ex_valid && !flush) begin
          if (ex_mem_read || ex_mem_write) begin
            take_mem  = 1'b1;
            state_nxt = ACCESS;
          end else begin
            take_alu = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          ack_done  = 1'b1;
          state_nxt = IDLE;
        end else if (timeout_hit) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; stall and mem_req are registered copies of "in ACCESS".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      stall   <= 1'b0;
      mem_req <= 1'b0;
    end else begin
      state   <= state_nxt;
      stall   <= (state_nxt == ACCESS);
      mem_req <= (state_nxt == ACCESS);
    end
  end

  // Capture the memory instruction; a store wins when both flags are set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cap_shift <= '0;
      cap_instr <= '0;
      cap_mux   <= '0;
    end else if (take_mem) begin
      mem_we    <= ex_mem_write;
      mem_addr  <= ex_alu_out;
      mem_wdata <= ex_store_data;
      cap_shift <= ex_shift_out;
      cap_instr <= ex_instruction;
      cap_mux   <= ex_reg_write_mux;
    end
  end

  // Pipeline register: direct load for ALU ops, captured fields on ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      EX_MEM_mem_out_data  <= '0;
      EX_MEM_alu_out       <= '0;
      EX_MEM_shift_out     <= '0;
      EX_MEM_instruction   <= '0;
      EX_MEM_reg_write_mux <= '0;
      EX_MEM_valid         <= 1'b0;
    end else begin
      EX_MEM_valid <= take_alu || ack_done;
      if (take_alu) begin
        EX_MEM_mem_out_data  <= '0;
        EX_MEM_alu_out       <= ex_alu_out;
        EX_MEM_shift_out     <= ex_shift_out;
        EX_MEM_instruction   <= ex_instruction;
        EX_MEM_reg_write_mux <= ex_reg_write_mux;
      end else if (ack_done) begin
        EX_MEM_mem_out_data  <= mem_we ? '0 : mem_rdata;
        EX_MEM_alu_out       <= mem_addr;
        EX_MEM_shift_out     <= cap_shift;
        EX_MEM_instruction   <= cap_instr;
        EX_MEM_reg_write_mux <= cap_mux;
      end
    end
  end

`ifdef EX_MEM_STAGE_TIMEOUT_EN
  logic mem_err_q;

  mem_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_mem_timeout_ctr (
    .clk     (clk),
    .reset   (reset),
    .start   (take_mem),
    .active  (state == ACCESS),
    .expired (timeout_hit)
  );

  // Sticky error: once an access is abandoned it stays flagged until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_err_q <= 1'b0;
    end else if (abort) begin
      mem_err_q <= 1'b1;
    end
  end

  assign mem_err = mem_err_q;
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign mem_err            = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0) || abort;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus randomized traffic.
// A transaction-level model predicts every registered output after each edge.
// Works with or without EX_MEM_STAGE_TIMEOUT_EN defined.
module tb_ex_mem_stage;

  localparam int DW = 8;
  localparam int IW = 19;
  localparam int TO = 15;
`ifdef EX_MEM_STAGE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          ex_valid, ex_mem_read, ex_mem_write, flush, mem_ack;
  logic [DW-1:0] ex_alu_out, ex_shift_out, ex_store_data, mem_rdata;
  logic [IW-1:0] ex_instruction;
  logic [1:0]    ex_reg_write_mux;
  logic          stall, mem_req, mem_we, EX_MEM_valid, mem_err;
  logic [DW-1:0] mem_addr, mem_wdata, EX_MEM_mem_out_data, EX_MEM_alu_out, EX_MEM_shift_out;
  logic [IW-1:0] EX_MEM_instruction;
  logic [1:0]    EX_MEM_reg_write_mux;

  ex_mem_stage #(.DATA_W(DW), .INSTR_W(IW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_alu_out(ex_alu_out),
    .ex_shift_out(ex_shift_out), .ex_store_data(ex_store_data),
    .ex_instruction(ex_instruction), .ex_reg_write_mux(ex_reg_write_mux),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .flush(flush),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .EX_MEM_mem_out_data(EX_MEM_mem_out_data), .EX_MEM_alu_out(EX_MEM_alu_out),
    .EX_MEM_shift_out(EX_MEM_shift_out), .EX_MEM_instruction(EX_MEM_instruction),
    .EX_MEM_reg_write_mux(EX_MEM_reg_write_mux), .EX_MEM_valid(EX_MEM_valid),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          stall, req, we, valid, err;
    logic [DW-1:0] addr, wdata, mo, alu, shift;
    logic [IW-1:0] instr;
    logic [1:0]    mux;
  } exp_t;

  // Model: one pending memory transaction (or none) plus the visible outputs.
  exp_t          exp_q, nxt;
  bit            m_busy;
  int            m_cyc;
  logic [DW-1:0] c_shift;
  logic [IW-1:0] c_instr;
  logic [1:0]    c_mux;

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic exp_t zero_exp();
    exp_t z;
    z.stall = 0; z.req = 0; z.we = 0; z.valid = 0; z.err = 0;
    z.addr = 0; z.wdata = 0; z.mo = 0; z.alu = 0; z.shift = 0; z.instr = 0; z.mux = 0;
    return z;
  endfunction

  task automatic model_reset();
    exp_q  = zero_exp();
    m_busy = 0;
    m_cyc  = 0;
  endtask

  // Predict the outputs after the coming edge from the inputs presented now.
  task automatic model_step();
    nxt = exp_q;
    nxt.valid = 0;
    if (reset) begin
      nxt = zero_exp();
      m_busy = 0;
    end else if (!m_busy) begin
      if (ex_valid && !flush) begin
        if (ex_mem_read || ex_mem_write) begin
          m_busy = 1; m_cyc = 0;
          c_shift = ex_shift_out; c_instr = ex_instruction; c_mux = ex_reg_write_mux;
          nxt.stall = 1; nxt.req = 1; nxt.we = ex_mem_write;
          nxt.addr = ex_alu_out; nxt.wdata = ex_store_data;
        end else begin
          nxt.valid = 1; nxt.mo = 0; nxt.alu = ex_alu_out; nxt.shift = ex_shift_out;
          nxt.instr = ex_instruction; nxt.mux = ex_reg_write_mux;
        end
      end
    end else begin
      m_cyc++;
      if (mem_ack) begin
        m_busy = 0;
        nxt.stall = 0; nxt.req = 0; nxt.valid = 1;
        nxt.mo = exp_q.we ? '0 : mem_rdata;
        nxt.alu = exp_q.addr; nxt.shift = c_shift; nxt.instr = c_instr; nxt.mux = c_mux;
      end else if (TO_EN && m_cyc == TO) begin
        m_busy = 0;
        nxt.stall = 0; nxt.req = 0; nxt.err = 1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    exp_q = nxt;
    #1;
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr, input logic [DW-1:0] alu,
                       input logic [DW-1:0] st, input logic [1:0] mux);
    ex_valid = v; ex_mem_read = rd; ex_mem_write = wr; ex_alu_out = alu;
    ex_store_data = st; ex_reg_write_mux = mux;
    ex_shift_out = DW'($urandom); ex_instruction = IW'($urandom);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".stall"}, stall, 0);        chk({tag, ".mem_req"}, mem_req, 0);
    chk({tag, ".mem_we"}, mem_we, 0);      chk({tag, ".mem_addr"}, mem_addr, 0);
    chk({tag, ".mem_wdata"}, mem_wdata, 0); chk({tag, ".valid"}, EX_MEM_valid, 0);
    chk({tag, ".mo"}, EX_MEM_mem_out_data, 0); chk({tag, ".alu"}, EX_MEM_alu_out, 0);
    chk({tag, ".shift"}, EX_MEM_shift_out, 0); chk({tag, ".instr"}, EX_MEM_instruction, 0);
    chk({tag, ".mux"}, EX_MEM_reg_write_mux, 0); chk({tag, ".err"}, mem_err, 0);
  endtask

  // Every cycle: DUT outputs against the model's prediction.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc.stall", stall, exp_q.stall);
      chk("cyc.mem_req", mem_req, exp_q.req);
      chk("cyc.valid", EX_MEM_valid, exp_q.valid);
      chk("cyc.mem_out", EX_MEM_mem_out_data, exp_q.mo);
      chk("cyc.alu", EX_MEM_alu_out, exp_q.alu);
      chk("cyc.shift", EX_MEM_shift_out, exp_q.shift);
      chk("cyc.instr", EX_MEM_instruction, exp_q.instr);
      chk("cyc.mux", EX_MEM_reg_write_mux, exp_q.mux);
      chk("cyc.err", mem_err, exp_q.err);
      if (exp_q.req) begin
        chk("cyc.mem_we", mem_we, exp_q.we);
        chk("cyc.mem_addr", mem_addr, exp_q.addr);
        chk("cyc.mem_wdata", mem_wdata, exp_q.wdata);
      end
    end
  end

  initial begin
    reset = 1; flush = 0; mem_ack = 0; mem_rdata = 0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    chk_en = 1;
    tick(); tick();
    chk_all_zero("reset");
    reset = 0;
    tick();

    // Plain ALU op passes through in one cycle.
    drive(1, 0, 0, 8'h3C, 8'h00, 2'd0);
    tick();
    chk("alu.out", EX_MEM_alu_out, 8'h3C); chk("alu.valid", EX_MEM_valid, 1);
    chk("alu.mo", EX_MEM_mem_out_data, 0); chk("alu.stall", stall, 0);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("alu.valid_drop", EX_MEM_valid, 0);

    // Load with ack seen on the third edge after mem_req rises.
    drive(1, 1, 0, 8'h10, 8'h00, 2'd2);
    tick();
    chk("ld.req", mem_req, 1); chk("ld.stall0", stall, 1);
    chk("ld.we", mem_we, 0); chk("ld.addr", mem_addr, 8'h10);
    drive(1, 0, 0, 8'hFF, 8'hEE, 2'd1);   // ignored while stalled
    tick();
    chk("ld.stall1", stall, 1); chk("ld.addr_hold", mem_addr, 8'h10);
    tick();
    chk("ld.stall2", stall, 1);
    mem_ack = 1; mem_rdata = 8'hA5;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    mem_ack = 0;
    chk("ld.stall_fall", stall, 0); chk("ld.data", EX_MEM_mem_out_data, 8'hA5);
    chk("ld.valid", EX_MEM_valid, 1); chk("ld.alu", EX_MEM_alu_out, 8'h10);
    tick();
    chk("ld.valid_once", EX_MEM_valid, 0);

    // Store (read+write both set) with flush pulsed mid-access.
    drive(1, 1, 1, 8'h20, 8'h77, 2'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    flush = 1;
    tick();
    flush = 0;
    chk("st.we", mem_we, 1); chk("st.wdata", mem_wdata, 8'h77);
    chk("st.addr", mem_addr, 8'h20); chk("st.req", mem_req, 1);
    tick();
    chk("st.wdata_hold", mem_wdata, 8'h77);
    mem_ack = 1; mem_rdata = 8'h5A;
    tick();
    mem_ack = 0;
    chk("st.valid", EX_MEM_valid, 1); chk("st.mo", EX_MEM_mem_out_data, 0);
    chk("b2b.gap", mem_req, 0);

    // Back-to-back: next load accepted in the single IDLE cycle.
    drive(1, 1, 0, 8'h30, 8'h00, 2'd2);
    tick();
    chk("b2b.req", mem_req, 1);
    drive(0, 0, 0, 0, 0, 0);
    mem_ack = 1; mem_rdata = 8'h11;
    tick();
    mem_ack = 0;

    // Flush in IDLE squashes and holds the previous fields.
    drive(1, 0, 0, 8'h99, 8'h00, 2'd0);
    flush = 1;
    tick();
    flush = 0;
    chk("flush.valid", EX_MEM_valid, 0); chk("flush.hold", EX_MEM_alu_out, 8'h30);

    // Reset one cycle into an access.
    drive(1, 1, 0, 8'h40, 8'h00, 2'd2);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    reset = 1;
    model_reset();
    #1;
    chk_all_zero("midrst");
    tick();
    reset = 0;

    // No ack: watchdog abort or indefinite wait.
    drive(1, 1, 0, 8'h50, 8'h00, 2'd2);
    tick();
    drive(0, 0, 0, 0, 0, 0);
`ifdef EX_MEM_STAGE_TIMEOUT_EN
    repeat (TO - 1) tick();
    chk("to.stall_before", stall, 1); chk("to.err_before", mem_err, 0);
    tick();
    chk("to.stall", stall, 0); chk("to.err", mem_err, 1); chk("to.valid", EX_MEM_valid, 0);
    repeat (3) tick();
    chk("to.err_sticky", mem_err, 1);
    reset = 1;
    model_reset();
    tick();
    reset = 0;
    chk("to.err_clr", mem_err, 0);
`else
    repeat (20) tick();
    chk("noto.stall", stall, 1); chk("noto.err", mem_err, 0); chk("noto.req", mem_req, 1);
    mem_ack = 1; mem_rdata = 8'h3E;
    tick();
    mem_ack = 0;
    chk("noto.done", EX_MEM_valid, 1); chk("noto.data", EX_MEM_mem_out_data, 8'h3E);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            DW'($urandom), DW'($urandom), 2'($urandom));
      flush     = ($urandom_range(0, 9) == 0);
      mem_ack   = ($urandom_range(0, 9) < 3);
      mem_rdata = DW'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1;
        model_reset();
        #1;
        chk("rnd.rst_req", mem_req, 0);
        chk("rnd.rst_stall", stall, 0);
        tick();
        reset = 0;
      end else begin
        tick();
      end
    end

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
